// File: rtl/ni_flit_injector_if.sv
// Core-side and router-side handshake bundle of the NI flit injector.
// Every valid/ready pair transfers one item on a rising clk edge where both are
// high; the producer holds valid and payload stable until that edge, and ready
// may depend on registered state only. flit_valid has no ready: the router
// always accepts, and credits guarantee a free VC slot.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

interface ni_flit_injector_if #(
   parameter int ROUTER_ID_BITS = 4,
   parameter int LEN_BITS       = 4,
   parameter int FLIT_W         = `FLIT_DATA_WIDTH,
   parameter int PLD_W          = FLIT_W - ROUTER_ID_BITS - 2
);
   logic                      pkt_valid;
   logic                      pkt_ready;
   logic [ROUTER_ID_BITS-1:0] pkt_dest;
   logic [LEN_BITS-1:0]       pkt_len;
   logic                      pld_valid;
   logic                      pld_ready;
   logic [PLD_W-1:0]          pld_data;
   logic                      credit_return;
   logic [FLIT_W-1:0]         flit_data;
   logic                      flit_valid;

   // Core / router environment side
   modport master (
      output pkt_valid, pkt_dest, pkt_len, pld_valid, pld_data, credit_return,
      input  pkt_ready, pld_ready, flit_data, flit_valid
   );

   // Injector side
   modport slave (
      input  pkt_valid, pkt_dest, pkt_len, pld_valid, pld_data, credit_return,
      output pkt_ready, pld_ready, flit_data, flit_valid
   );
endinterface

// File: rtl/ni_flit_injector.sv
// NI transmitter: turns a packet descriptor plus payload words into typed flits
// for one router input port, gated by a downstream VC credit counter.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module ni_flit_injector #(
   parameter  int NUM_VC         = 4,
   parameter  int NUM_ROUTERS    = 16,
   parameter  int MAX_PKT_FLITS  = 8,
   localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
   localparam int LEN_BITS       = $clog2(MAX_PKT_FLITS + 1),
   localparam int CRED_BITS      = $clog2(NUM_VC + 1),
   localparam int FLIT_W         = `FLIT_DATA_WIDTH,
   localparam int PLD_W          = FLIT_W - ROUTER_ID_BITS - 2
) (
   input  logic                 clk,
   input  logic                 reset,
   ni_flit_injector_if.slave    bus,
   output logic [CRED_BITS-1:0] credits,
   output logic                 busy,
   output logic                 credit_err,
   output logic                 o_dbg_state
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   localparam logic [1:0] TYPE_BODY      = 2'b00;
   localparam logic [1:0] TYPE_HEAD      = 2'b01;
   localparam logic [1:0] TYPE_TAIL      = 2'b10;
   localparam logic [1:0] TYPE_HEAD_TAIL = 2'b11;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ROUTER_ID_BITS-1:0] r_dest;
   logic [LEN_BITS-1:0]       r_len;
   logic [LEN_BITS-1:0]       r_cnt;
   logic [CRED_BITS-1:0]      r_credits;
   logic                      r_credit_err;
   logic [FLIT_W-1:0]         r_flit_data;
   logic                      r_flit_valid;

   logic                      w_pkt_ready;
   logic                      w_pld_ready;
   logic                      w_accept;
   logic                      w_send;
   logic                      w_last;
   logic [LEN_BITS-1:0]       w_len_clamped;
   logic [1:0]                w_type;

   assign w_accept = bus.pkt_valid & w_pkt_ready;
   assign w_send   = bus.pld_valid & w_pld_ready;
   assign w_last   = (r_cnt == (r_len - LEN_BITS'(1)));

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and handshake readies; pld_ready uses the registered credit count only
   always_comb begin
      w_state_nxt = r_state;
      w_pkt_ready = 1'b0;
      w_pld_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_pkt_ready = 1'b1;
            if (bus.pkt_valid) begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            w_pld_ready = (r_credits != '0);
            if (bus.pld_valid && w_pld_ready && w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Length normalisation: zero means a single flit, oversize is clamped
   always_comb begin
      w_len_clamped = bus.pkt_len;
      if (bus.pkt_len == '0) begin
         w_len_clamped = LEN_BITS'(1);
      end else if (bus.pkt_len > LEN_BITS'(MAX_PKT_FLITS)) begin
         w_len_clamped = LEN_BITS'(MAX_PKT_FLITS);
      end
   end

   // Flit type from position within the packet
   always_comb begin
      w_type = TYPE_BODY;
      if (r_len == LEN_BITS'(1)) begin
         w_type = TYPE_HEAD_TAIL;
      end else if (r_cnt == '0) begin
         w_type = TYPE_HEAD;
      end else if (w_last) begin
         w_type = TYPE_TAIL;
      end
   end

   // Descriptor latch, flit counter and registered flit output
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dest       <= '0;
         r_len        <= '0;
         r_cnt        <= '0;
         r_flit_data  <= '0;
         r_flit_valid <= 1'b0;
      end else begin
         r_flit_valid <= w_send;
         if (w_accept) begin
            r_dest <= bus.pkt_dest;
            r_len  <= w_len_clamped;
            r_cnt  <= '0;
         end
         if (w_send) begin
            r_flit_data <= {r_dest, w_type, bus.pld_data};
            r_cnt       <= r_cnt + LEN_BITS'(1);
         end
      end
   end

   // Credit counter; a return with no outstanding credit saturates and flags an error
   always_ff @(posedge clk) begin
      if (reset) begin
         r_credits    <= CRED_BITS'(NUM_VC);
         r_credit_err <= 1'b0;
      end else begin
         case ({w_send, bus.credit_return})
            2'b01: begin
               if (r_credits == CRED_BITS'(NUM_VC)) begin
                  r_credit_err <= 1'b1;
               end else begin
                  r_credits <= r_credits + CRED_BITS'(1);
               end
            end
            2'b10: begin
               r_credits <= r_credits - CRED_BITS'(1);
            end
            default: begin
               r_credits <= r_credits;
            end
         endcase
      end
   end

   assign bus.pkt_ready  = w_pkt_ready;
   assign bus.pld_ready  = w_pld_ready;
   assign bus.flit_data  = r_flit_data;
   assign bus.flit_valid = r_flit_valid;
   assign credits        = r_credits;
   assign busy           = (r_state == ST_SEND);
   assign credit_err     = r_credit_err;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_ni_flit_injector.sv
// Bench for ni_flit_injector: directed scenarios followed by random traffic,
// all checked against a packet-level reference model and a flit scoreboard.
module tb_ni_flit_injector;

   localparam int NUM_VC = 4;
   localparam int MAX_F  = 8;

   logic       clk;
   logic       reset;
   logic [2:0] credits;
   logic       busy;
   logic       credit_err;
   logic       dbg_state;

   ni_flit_injector_if bus ();

   ni_flit_injector dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .credits     (credits),
      .busy        (busy),
      .credit_err  (credit_err),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   // reference model: packet-level view of the injector
   bit          m_in_pkt;
   int          m_cred;
   bit          m_err;
   int          m_n;
   int          m_idx;
   logic [3:0]  m_dest;
   bit          m_fv;
   logic [31:0] m_fdata;

   int          n_flits = 0;
   logic [31:0] last_flit = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] flit_type(input int idx, input int n);
      if (n == 1)          return 2'b11;
      else if (idx == 0)   return 2'b01;
      else if (idx == n-1) return 2'b10;
      else                 return 2'b00;
   endfunction

   task automatic model_step(input bit rst, input bit pv, input logic [3:0] d,
                             input logic [3:0] l, input bit dv, input logic [25:0] pd,
                             input bit cr);
      bit pld_rdy;
      bit pkt_rdy;
      bit send;
      if (rst) begin
         m_in_pkt = 0;
         m_cred   = NUM_VC;
         m_err    = 0;
         m_n      = 0;
         m_idx    = 0;
         m_dest   = '0;
         m_fv     = 0;
         m_fdata  = '0;
         exp_q.delete();
         return;
      end
      pkt_rdy = !m_in_pkt;
      pld_rdy = m_in_pkt && (m_cred > 0);
      send    = dv && pld_rdy;
      m_fv    = send;
      if (send) begin
         m_fdata = {m_dest, flit_type(m_idx, m_n), pd};
         exp_q.push_back(m_fdata);
         m_idx++;
         if (m_idx == m_n) m_in_pkt = 0;
      end
      if (send && cr) begin
         // one slot taken, one slot freed
      end else if (cr) begin
         if (m_cred == NUM_VC) m_err = 1;
         else                  m_cred++;
      end else if (send) begin
         m_cred--;
      end
      if (pv && pkt_rdy) begin
         m_in_pkt = 1;
         m_dest   = d;
         m_n      = (l == 0) ? 1 : ((int'(l) > MAX_F) ? MAX_F : int'(l));
         m_idx    = 0;
      end
   endtask

   task automatic check_outputs();
      logic [31:0] e;
      chk("flit_valid", 32'(bus.flit_valid), 32'(m_fv));
      chk("flit_data", bus.flit_data, m_fdata);
      if (bus.flit_valid) begin
         n_flits++;
         last_flit = bus.flit_data;
         chk("sb_depth", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_flit", bus.flit_data, e);
         end
      end
      exp_q.delete();
      chk("credits", 32'(credits), 32'(m_cred));
      chk("busy", 32'(busy), 32'(m_in_pkt));
      chk("credit_err", 32'(credit_err), 32'(m_err));
      chk("pkt_ready", 32'(bus.pkt_ready), 32'(!m_in_pkt));
      chk("pld_ready", 32'(bus.pld_ready), 32'(m_in_pkt && (m_cred > 0)));
   endtask

   // driver: one clock cycle with the given inputs, model updated, outputs checked
   task automatic cycle(input bit rst, input bit pv, input logic [3:0] d, input logic [3:0] l,
                        input bit dv, input logic [25:0] pd, input bit cr);
      reset             = rst;
      bus.pkt_valid     = pv;
      bus.pkt_dest      = d;
      bus.pkt_len       = l;
      bus.pld_valid     = dv;
      bus.pld_data      = pd;
      bus.credit_return = cr;
      model_step(rst, pv, d, l, dv, pd, cr);
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, 0);
   endtask

   task automatic send_pkt(input logic [3:0] d, input logic [3:0] l);
      cycle(0, 1, d, l, 0, '0, 0);
   endtask

   task automatic pld(input logic [25:0] pd, input bit cr);
      cycle(0, 0, '0, '0, 1, pd, cr);
   endtask

   task automatic ret(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, 1);
   endtask

   initial begin
      int base;
      bit rr, pv, dv, cr;

      // reset state
      cycle(1, 0, '0, '0, 0, '0, 0);
      cycle(1, 0, '0, '0, 0, '0, 0);
      chk("rst_credits", 32'(credits), 32'd4);
      chk("rst_flit_data", bus.flit_data, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      idle(1);

      // single-flit packet
      send_pkt(4'd9, 4'd1);
      pld(26'h5, 0);
      chk("single_flit", bus.flit_data, 32'h9C00_0005);
      chk("single_valid", 32'(bus.flit_valid), 32'd1);
      chk("single_credits", 32'(credits), 32'd3);
      chk("single_idle", 32'(bus.pkt_ready), 32'd1);
      ret(1);

      // three-flit packet, back-to-back
      send_pkt(4'd3, 4'd3);
      pld(26'h1, 0);
      chk("p3_head", bus.flit_data, 32'h3400_0001);
      pld(26'h2, 0);
      chk("p3_body", bus.flit_data, 32'h3000_0002);
      pld(26'h3, 0);
      chk("p3_tail", bus.flit_data, 32'h3800_0003);
      ret(3);

      // credit exhaustion with a 6-flit packet
      send_pkt(4'd5, 4'd6);
      for (int k = 1; k <= 6; k++) pld(26'(k), 0);
      chk("exh_pld_ready", 32'(bus.pld_ready), 32'd0);
      chk("exh_credits", 32'(credits), 32'd0);
      cycle(0, 0, '0, '0, 1, 26'h5, 1);
      chk("exh_ret_credits", 32'(credits), 32'd1);
      chk("exh_ret_novalid", 32'(bus.flit_valid), 32'd0);
      pld(26'h5, 0);
      chk("exh_5th", bus.flit_data, 32'h5000_0005);
      chk("exh_5th_valid", 32'(bus.flit_valid), 32'd1);
      cycle(0, 0, '0, '0, 1, 26'h6, 1);
      pld(26'h6, 0);
      chk("exh_tail", bus.flit_data, 32'h5800_0006);

      // coincident send and return, then overflow
      ret(2);
      send_pkt(4'd1, 4'd2);
      pld(26'h7, 1);
      chk("coinc_credits", 32'(credits), 32'd2);
      chk("coinc_head", bus.flit_data, 32'h1400_0007);
      pld(26'h8, 0);
      chk("coinc_tail", bus.flit_data, 32'h1800_0008);
      ret(3);
      ret(1);
      chk("ovf_credits", 32'(credits), 32'd4);
      chk("ovf_err", 32'(credit_err), 32'd1);
      ret(1);
      chk("ovf_sticky", 32'(credit_err), 32'd1);

      // zero length means one HEAD_TAIL flit
      cycle(1, 0, '0, '0, 0, '0, 0);
      chk("clr_err", 32'(credit_err), 32'd0);
      send_pkt(4'd2, 4'd0);
      pld(26'h9, 0);
      chk("len0_flit", bus.flit_data, 32'h2C00_0009);
      ret(1);

      // oversize length clamps to the maximum
      send_pkt(4'hA, 4'd12);
      base = n_flits;
      for (int k = 0; k < 12; k++) pld(26'(k + 16), m_in_pkt);
      chk("len12_count", 32'(n_flits - base), 32'd8);
      chk("len12_last_type", 32'(last_flit[27:26]), 32'd2);
      chk("len12_idle", 32'(busy), 32'd0);

      // reset mid-packet abandons it
      send_pkt(4'd6, 4'd5);
      pld(26'h11, 0);
      pld(26'h12, 0);
      cycle(1, 0, '0, '0, 0, '0, 0);
      chk("mid_rst_valid", 32'(bus.flit_valid), 32'd0);
      chk("mid_rst_credits", 32'(credits), 32'd4);
      chk("mid_rst_pkt_ready", 32'(bus.pkt_ready), 32'd1);
      base = n_flits;
      for (int k = 0; k < 4; k++) pld(26'h13, 0);
      chk("mid_rst_no_tail", 32'(n_flits - base), 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(0, 249) == 0);
         pv = ($urandom_range(0, 1) == 1);
         dv = ($urandom_range(0, 9) < 7);
         if (m_cred < NUM_VC) cr = ($urandom_range(0, 2) == 0);
         else                 cr = ($urandom_range(0, 59) == 0);
         cycle(rr, pv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 12)),
               dv, 26'($urandom), cr);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
